bit_serial_alu_seq: RTL

// - Bit-serial sequencer that sits directly upstream of the 1-bit MSB/SLT ALU slice.
// - Accepts WIDTH-bit operands and a 4-bit ALU control word over a valid/ready handshake.
// - Drives the slice one bit per cycle, LSB first, and assembles the WIDTH-bit result.
// - Reports result, overflow and zero flags to the consumer over a valid/ready handshake.

---
 rtl/bit_serial_alu_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial sequencer: walks a 1-bit MSB/SLT ALU slice LSB first and assembles the result.
// Latency WIDTH+1 cycles from accept; in_ready low while busy/done; holds DONE until out_ready.
module bit_serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_ctl,
  output logic             alu_in1,
  output logic             alu_in2,
  output logic             alu_cin,
  output logic             alu_ainvert,
  output logic             alu_binvert,
  output logic [1:0]       alu_op,
  output logic             alu_less,
  input  logic             alu_result,
  input  logic             alu_set,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_zero
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [3:0]       r_ctl;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_ovf;
  logic             r_set;

  logic             w_last;
  logic             w_accept;
  logic             w_abit;
  logic             w_bbit;
  logic             w_slt;
  logic [WIDTH-1:0] w_final;

  assign w_last   = (r_idx == IW'(WIDTH - 1));
  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_abit   = r_a[r_idx] ^ r_ctl[3];
  assign w_bbit   = r_b[r_idx] ^ r_ctl[2];
  assign w_slt    = (r_ctl[1:0] == 2'b11);
  // The slice returns 0 for every SLT bit; the raw sign is inserted at bit 0 here.
  assign w_final  = w_slt ? {{(WIDTH-1){1'b0}}, r_set} : r_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BUSY;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_ctl   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_set   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_ctl   <= in_ctl;
      r_res   <= '0;
      r_idx   <= '0;
      r_carry <= in_ctl[2];
      r_ovf   <= 1'b0;
      r_set   <= 1'b0;
    end else if (r_state == S_BUSY) begin
      r_res[r_idx] <= alu_result;
      // The slice exposes no carry-out, so the ripple carry is rebuilt here.
      r_carry <= (w_abit & w_bbit) | (w_abit & r_carry) | (w_bbit & r_carry);
      if (w_last) begin
        r_idx <= '0;
        r_ovf <= alu_overflow;
        r_set <= alu_set;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    in_ready     = 1'b0;
    alu_in1      = 1'b0;
    alu_in2      = 1'b0;
    alu_cin      = 1'b0;
    alu_ainvert  = 1'b0;
    alu_binvert  = 1'b0;
    alu_op       = 2'b00;
    alu_less     = 1'b0;
    out_valid    = 1'b0;
    out_result   = '0;
    out_overflow = 1'b0;
    out_zero     = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_BUSY: begin
        alu_in1     = r_a[r_idx];
        alu_in2     = r_b[r_idx];
        alu_cin     = r_carry;
        alu_ainvert = r_ctl[3];
        alu_binvert = r_ctl[2];
        alu_op      = r_ctl[1:0];
      end
      S_DONE: begin
        out_valid    = 1'b1;
        out_result   = w_final;
        out_overflow = (r_ctl[1:0] == 2'b10) && r_ovf;
        out_zero     = (w_final == '0);
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule
